tabellone_morra: RTL and testbench
==================================

# tabellone_morra

Scoreboard stage directly downstream of the rock-paper-scissors game FSM. It samples the FSM's per-round code (`manche`) and end-of-game code (`partita`) every clock and keeps per-player and draw tallies plus a 3-deep round history. It latches the final game result and presents it to the display stage with a valid/ack handshake. It also flags games whose declared winner contradicts its own tallies.

## Interface
Parameters:
- `W_CNT`, default 4: width of the per-player and draw counters. These saturate at 2^W_CNT−1.
- `W_TOT`, default 5: width of the total-rounds counter. It saturates at 2^W_TOT−1.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `inizio`  in  1  synchronous, active-high reset. Also starts a new game.
- `manche`  in  2  round code: 00 none, 01 player 1 won, 10 player 2 won, 11 draw.
- `partita`  in  2  game code: 00 still running, 01 player 1 wins, 10 player 2 wins, 11 tie.
- `ack`  in  1  display has consumed the result.
- `vinte1`  out  W_CNT  rounds won by player 1.
- `vinte2`  out  W_CNT  rounds won by player 2.
- `pari`  out  W_CNT  drawn rounds.
- `giocate`  out  W_TOT  total counted rounds.
- `storico`  out  6  last three nonzero round codes. Bits [1:0] are the newest.
- `esito`  out  2  latched game result.
- `esito_valido`  out  1  `esito` is valid and awaiting `ack`.
- `chiusa`  out  1  game closed; result has been acknowledged.
- `errore`  out  1  sticky flag: declared result is inconsistent with the tallies.

## Operation
- The state machine has three states: GIOCO, ESITO and CHIUSA. Encode them as 2 bits.
- On `inizio`=1 at an edge:
  - the state goes to GIOCO;
  - every output and counter is cleared to 0.
  - `inizio` has priority over every other input in every state, including mid-handshake.
- The upstream contract is one clock per round: each cycle with `manche`≠00 is one new round. Holding a nonzero code for N cycles counts N rounds.
- **GIOCO**, per edge:
  - 01: `vinte1`+1.
  - 10: `vinte2`+1.
  - 11: `pari`+1.
  - On any nonzero code: `giocate`+1, and `storico` ← {`storico`[3:0], `manche`}.
  - 00: no change.
  - All counters saturate and never wrap. Saturation of one counter does not block updates to the others.
- **GIOCO, `partita`≠00:**
  - `esito` ← `partita`.
  - `esito_valido` ← 1.
  - The state goes to ESITO.
  - If `manche` is nonzero in the same cycle, that round is counted first, in the same edge.
- **Consistency check.** It is evaluated at the GIOCO→ESITO edge, against the tallies *including* the same-cycle round. `errore` ← 1 if any of these holds:
  - `partita`=01 and `vinte1`≤`vinte2`;
  - `partita`=10 and `vinte2`≤`vinte1`;
  - `partita`=11 and `vinte1`≠`vinte2`.
  - `errore` is sticky until `inizio`.
- **ESITO:**
  - `manche` and `partita` are ignored; counters and `storico` are frozen.
  - `esito` and `esito_valido` are held stable until `ack`=1 is sampled.
  - On `ack`=1: `esito_valido` ← 0, `chiusa` ← 1, and the state goes to CHIUSA.
- **CHIUSA:**
  - Everything is frozen; `esito` keeps its value.
  - Only `inizio` leaves this state.
- `ack` is ignored in GIOCO and CHIUSA.

## Timing
- All outputs are registered and driven directly from flops. There is no combinational input-to-output path.
- Round latency: counters and `storico` reflect `manche` from cycle N at cycle N+1, i.e. after edge N.
- Result latency: with `partita`≠00 sampled at edge N, `esito_valido`=1 and `esito` are valid from edge N until the `ack` edge.
- Minimum handshake: `esito_valido` is high for 1 cycle if `ack` is already high at the following edge. After the `ack` edge, `esito_valido`=0 and `chiusa`=1.
- Reset mid-operation: the first cycle after an `inizio` edge shows all outputs at 0. A `manche` presented in the same cycle as `inizio` is not counted.

## Test plan
- **Basic tally.** Reset, then `manche` = 01, 10, 11, 01, 00, 01 on consecutive cycles, `partita`=00 → `vinte1`=3, `vinte2`=1, `pari`=1, `giocate`=5, `storico`=6'b11_01_01, `esito_valido`=0.
- **Result handshake.** After the basic tally, `partita`=01 for one cycle with `ack` held 0 for 3 cycles, then `ack`=1 → `esito`=01 and `esito_valido`=1 for exactly 4 cycles. Then `esito_valido`=0, `chiusa`=1, `errore`=0. Further `manche`=01 does not change `vinte1`.
- **Same-cycle round and result.** From tallies 1–1, present `manche`=10 with `partita`=10 in the same cycle → `vinte2`=2, `giocate`=3, `esito`=10, `errore`=0.
- **Inconsistency.** From tallies 2–0, `partita`=10 → `errore`=1, `esito`=10. `errore` stays 1 through `ack` and CHIUSA, and clears only on `inizio`.
- **Saturation.** Hold `manche`=01 for 20 cycles → `vinte1`=15, `giocate`=20. Then hold `manche`=11 for 15 cycles → `pari`=15, `giocate`=31, `vinte1` still 15.
- **Reset mid-handshake.** In ESITO with `esito_valido`=1, assert `inizio` together with `ack`=1 and `manche`=01 → next cycle all outputs are 0, the state is GIOCO, and `chiusa`=0.

Source files
------------

// File: rtl/tabellone_morra.sv
// Scoreboard stage behind the rock-paper-scissors FSM: round tallies,
// 3-deep history and a latched game result with a valid/ack handshake.
module tabellone_morra #(
  parameter int W_CNT = 4,
  parameter int W_TOT = 5
) (
  input  logic             clk,
  input  logic             inizio,
  input  logic [1:0]       manche,
  input  logic [1:0]       partita,
  input  logic             ack,
  output logic [W_CNT-1:0] vinte1,
  output logic [W_CNT-1:0] vinte2,
  output logic [W_CNT-1:0] pari,
  output logic [W_TOT-1:0] giocate,
  output logic [5:0]       storico,
  output logic [1:0]       esito,
  output logic             esito_valido,
  output logic             chiusa,
  output logic             errore
);

  typedef enum logic [1:0] {
    GIOCO  = 2'd0,
    ESITO  = 2'd1,
    CHIUSA = 2'd2
  } stato_e;

  localparam logic [W_CNT-1:0] CNT_MAX = '1;
  localparam logic [W_TOT-1:0] TOT_MAX = '1;

  stato_e           state_q, state_d;
  logic [W_CNT-1:0] vinte1_q, vinte1_d;
  logic [W_CNT-1:0] vinte2_q, vinte2_d;
  logic [W_CNT-1:0] pari_q, pari_d;
  logic [W_TOT-1:0] giocate_q, giocate_d;
  logic [5:0]       storico_q, storico_d;
  logic [1:0]       esito_q, esito_d;
  logic             esito_valido_q, esito_valido_d;
  logic             chiusa_q, chiusa_d;
  logic             errore_q, errore_d;
  logic             incoerente;

  always_ff @(posedge clk) begin
    if (inizio) begin
      state_q        <= GIOCO;
      vinte1_q       <= '0;
      vinte2_q       <= '0;
      pari_q         <= '0;
      giocate_q      <= '0;
      storico_q      <= '0;
      esito_q        <= '0;
      esito_valido_q <= 1'b0;
      chiusa_q       <= 1'b0;
      errore_q       <= 1'b0;
    end else begin
      state_q        <= state_d;
      vinte1_q       <= vinte1_d;
      vinte2_q       <= vinte2_d;
      pari_q         <= pari_d;
      giocate_q      <= giocate_d;
      storico_q      <= storico_d;
      esito_q        <= esito_d;
      esito_valido_q <= esito_valido_d;
      chiusa_q       <= chiusa_d;
      errore_q       <= errore_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      GIOCO:   if (partita != 2'b00) state_d = ESITO;
      ESITO:   if (ack) state_d = CHIUSA;
      CHIUSA:  state_d = CHIUSA;
      default: state_d = GIOCO;
    endcase
  end

  always_comb begin
    vinte1_d       = vinte1_q;
    vinte2_d       = vinte2_q;
    pari_d         = pari_q;
    giocate_d      = giocate_q;
    storico_d      = storico_q;
    esito_d        = esito_q;
    esito_valido_d = esito_valido_q;
    chiusa_d       = chiusa_q;
    errore_d       = errore_q;
    incoerente     = 1'b0;
    if (state_q == GIOCO) begin
      unique case (manche)
        2'b01:   if (vinte1_q != CNT_MAX) vinte1_d = vinte1_q + 1'b1;
        2'b10:   if (vinte2_q != CNT_MAX) vinte2_d = vinte2_q + 1'b1;
        2'b11:   if (pari_q != CNT_MAX) pari_d = pari_q + 1'b1;
        default: ;
      endcase
      if (manche != 2'b00) begin
        if (giocate_q != TOT_MAX) giocate_d = giocate_q + 1'b1;
        storico_d = {storico_q[3:0], manche};
      end
      // Check against tallies that already include this cycle's round
      unique case (partita)
        2'b01:   incoerente = (vinte1_d <= vinte2_d);
        2'b10:   incoerente = (vinte2_d <= vinte1_d);
        2'b11:   incoerente = (vinte1_d != vinte2_d);
        default: incoerente = 1'b0;
      endcase
      if (partita != 2'b00) begin
        esito_d        = partita;
        esito_valido_d = 1'b1;
        errore_d       = errore_q | incoerente;
      end
    end
    if (state_q == ESITO && ack) begin
      esito_valido_d = 1'b0;
      chiusa_d       = 1'b1;
    end
  end

  assign vinte1       = vinte1_q;
  assign vinte2       = vinte2_q;
  assign pari         = pari_q;
  assign giocate      = giocate_q;
  assign storico      = storico_q;
  assign esito        = esito_q;
  assign esito_valido = esito_valido_q;
  assign chiusa       = chiusa_q;
  assign errore       = errore_q;

endmodule

// File: tb/tb_tabellone_morra.sv
// Directed vector bench for tabellone_morra: tallies, handshake,
// consistency flag, saturation and reset priority.
module tb_tabellone_morra;

  logic       clk = 1'b0;
  logic       inizio = 1'b0;
  logic [1:0] manche = 2'b00;
  logic [1:0] partita = 2'b00;
  logic       ack = 1'b0;
  logic [3:0] vinte1, vinte2, pari;
  logic [4:0] giocate;
  logic [5:0] storico;
  logic [1:0] esito;
  logic       esito_valido, chiusa, errore;

  int n_vec = 0;
  int n_bad = 0;

  tabellone_morra #(.W_CNT(4), .W_TOT(5)) dut (
    .clk(clk), .inizio(inizio), .manche(manche), .partita(partita),
    .ack(ack), .vinte1(vinte1), .vinte2(vinte2), .pari(pari),
    .giocate(giocate), .storico(storico), .esito(esito),
    .esito_valido(esito_valido), .chiusa(chiusa), .errore(errore)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       ini;
    logic       ack;
    logic [1:0] m;
    logic [1:0] p;
    logic [27:0] exp;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [27:0] pk(
    input logic [3:0] v1, input logic [3:0] v2, input logic [3:0] pa,
    input logic [4:0] gi, input logic [5:0] st, input logic [1:0] es,
    input logic ev, input logic ch, input logic er);
    return {v1, v2, pa, gi, st, es, ev, ch, er};
  endfunction

  function automatic void add(
    input logic ini, input logic a, input logic [1:0] m,
    input logic [1:0] p, input logic [27:0] e);
    vec_t v;
    v.ini = ini; v.ack = a; v.m = m; v.p = p; v.exp = e;
    tbl.push_back(v);
  endfunction

  task automatic step(input logic ini, input logic a,
                      input logic [1:0] m, input logic [1:0] p);
    inizio = ini; ack = a; manche = m; partita = p;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [27:0] e);
    logic [27:0] got;
    got = {vinte1, vinte2, pari, giocate, storico, esito,
           esito_valido, chiusa, errore};
    n_vec++;
    if (got !== e) begin
      n_bad++;
      $display("FAIL %s: got v1=%0d v2=%0d pa=%0d gi=%0d st=%b es=%b ev=%b ch=%b er=%b, want %h got %h",
               name, vinte1, vinte2, pari, giocate, storico, esito,
               esito_valido, chiusa, errore, e, got);
    end
  endtask

  initial begin
    // basic tally (ack in GIOCO must be ignored)
    add(1, 0, 2'b00, 2'b00, pk(0, 0, 0, 0, 6'b000000, 0, 0, 0, 0));
    add(0, 1, 2'b01, 2'b00, pk(1, 0, 0, 1, 6'b000001, 0, 0, 0, 0));
    add(0, 0, 2'b10, 2'b00, pk(1, 1, 0, 2, 6'b000110, 0, 0, 0, 0));
    add(0, 0, 2'b11, 2'b00, pk(1, 1, 1, 3, 6'b011011, 0, 0, 0, 0));
    add(0, 0, 2'b01, 2'b00, pk(2, 1, 1, 4, 6'b101101, 0, 0, 0, 0));
    add(0, 0, 2'b00, 2'b00, pk(2, 1, 1, 4, 6'b101101, 0, 0, 0, 0));
    add(0, 0, 2'b01, 2'b00, pk(3, 1, 1, 5, 6'b110101, 0, 0, 0, 0));
    // handshake: valid for 4 cycles, then closed and frozen
    add(0, 0, 2'b00, 2'b01, pk(3, 1, 1, 5, 6'b110101, 1, 1, 0, 0));
    add(0, 0, 2'b01, 2'b11, pk(3, 1, 1, 5, 6'b110101, 1, 1, 0, 0));
    add(0, 0, 2'b01, 2'b10, pk(3, 1, 1, 5, 6'b110101, 1, 1, 0, 0));
    add(0, 0, 2'b11, 2'b00, pk(3, 1, 1, 5, 6'b110101, 1, 1, 0, 0));
    add(0, 1, 2'b00, 2'b00, pk(3, 1, 1, 5, 6'b110101, 1, 0, 1, 0));
    add(0, 0, 2'b01, 2'b00, pk(3, 1, 1, 5, 6'b110101, 1, 0, 1, 0));
    add(0, 1, 2'b10, 2'b10, pk(3, 1, 1, 5, 6'b110101, 1, 0, 1, 0));
    // same-cycle round and result
    add(1, 0, 2'b00, 2'b00, pk(0, 0, 0, 0, 6'b000000, 0, 0, 0, 0));
    add(0, 0, 2'b01, 2'b00, pk(1, 0, 0, 1, 6'b000001, 0, 0, 0, 0));
    add(0, 0, 2'b10, 2'b00, pk(1, 1, 0, 2, 6'b000110, 0, 0, 0, 0));
    add(0, 0, 2'b10, 2'b10, pk(1, 2, 0, 3, 6'b011010, 2, 1, 0, 0));
    add(0, 1, 2'b00, 2'b00, pk(1, 2, 0, 3, 6'b011010, 2, 0, 1, 0));
    // inconsistency, sticky through ack and CHIUSA
    add(1, 0, 2'b00, 2'b00, pk(0, 0, 0, 0, 6'b000000, 0, 0, 0, 0));
    add(0, 0, 2'b01, 2'b00, pk(1, 0, 0, 1, 6'b000001, 0, 0, 0, 0));
    add(0, 0, 2'b01, 2'b00, pk(2, 0, 0, 2, 6'b000101, 0, 0, 0, 0));
    add(0, 0, 2'b00, 2'b10, pk(2, 0, 0, 2, 6'b000101, 2, 1, 0, 1));
    add(0, 1, 2'b00, 2'b00, pk(2, 0, 0, 2, 6'b000101, 2, 0, 1, 1));
    add(0, 0, 2'b01, 2'b00, pk(2, 0, 0, 2, 6'b000101, 2, 0, 1, 1));
    add(1, 0, 2'b00, 2'b00, pk(0, 0, 0, 0, 6'b000000, 0, 0, 0, 0));
    // tie declared with equal tallies is consistent
    add(0, 0, 2'b11, 2'b00, pk(0, 0, 1, 1, 6'b000011, 0, 0, 0, 0));
    add(0, 0, 2'b00, 2'b11, pk(0, 0, 1, 1, 6'b000011, 3, 1, 0, 0));
    // p1 declared winner on equal tallies is inconsistent
    add(1, 0, 2'b00, 2'b00, pk(0, 0, 0, 0, 6'b000000, 0, 0, 0, 0));
    add(0, 0, 2'b01, 2'b00, pk(1, 0, 0, 1, 6'b000001, 0, 0, 0, 0));
    add(0, 0, 2'b10, 2'b01, pk(1, 1, 0, 2, 6'b000110, 1, 1, 0, 1));

    @(negedge clk);
    foreach (tbl[i]) begin
      step(tbl[i].ini, tbl[i].ack, tbl[i].m, tbl[i].p);
      chk($sformatf("vec%0d", i), tbl[i].exp);
    end

    // saturation
    step(1, 0, 2'b00, 2'b00);
    for (int i = 0; i < 20; i++) step(0, 0, 2'b01, 2'b00);
    chk("sat_v1", pk(15, 0, 0, 20, 6'b010101, 0, 0, 0, 0));
    for (int i = 0; i < 15; i++) step(0, 0, 2'b11, 2'b00);
    chk("sat_pari", pk(15, 0, 15, 31, 6'b111111, 0, 0, 0, 0));

    // reset wins over ack and manche mid-handshake
    step(1, 0, 2'b00, 2'b00);
    step(0, 0, 2'b01, 2'b01);
    chk("mid_esito", pk(1, 0, 0, 1, 6'b000001, 1, 1, 0, 0));
    step(1, 1, 2'b01, 2'b00);
    chk("mid_reset", pk(0, 0, 0, 0, 6'b000000, 0, 0, 0, 0));
    step(0, 1, 2'b00, 2'b00);
    chk("mid_idle", pk(0, 0, 0, 0, 6'b000000, 0, 0, 0, 0));
    step(0, 0, 2'b01, 2'b00);
    chk("mid_gioco", pk(1, 0, 0, 1, 6'b000001, 0, 0, 0, 0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
